// File: rtl/apb_chip_ctrl_arbiter.sv
// Two-requester APB arbiter in front of the chip-control register bus.
// Round-robin grant, one master transfer at a time, ACCESS-phase timeout.
module apb_chip_ctrl_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    soc_clk_i,
    input  logic                    soc_rstn_synced_i,
    input  logic [ADDR_WIDTH-1:0]   s0_paddr_i,
    input  logic [2:0]              s0_pprot_i,
    input  logic                    s0_psel_i,
    input  logic                    s0_penable_i,
    input  logic                    s0_pwrite_i,
    input  logic [DATA_WIDTH-1:0]   s0_pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] s0_pstrb_i,
    output logic [DATA_WIDTH-1:0]   s0_prdata_o,
    output logic                    s0_pready_o,
    output logic                    s0_pslverr_o,
    input  logic [ADDR_WIDTH-1:0]   s1_paddr_i,
    input  logic [2:0]              s1_pprot_i,
    input  logic                    s1_psel_i,
    input  logic                    s1_penable_i,
    input  logic                    s1_pwrite_i,
    input  logic [DATA_WIDTH-1:0]   s1_pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] s1_pstrb_i,
    output logic [DATA_WIDTH-1:0]   s1_prdata_o,
    output logic                    s1_pready_o,
    output logic                    s1_pslverr_o,
    output logic [ADDR_WIDTH-1:0]   m_paddr_o,
    output logic [2:0]              m_pprot_o,
    output logic                    m_psel_o,
    output logic                    m_penable_o,
    output logic                    m_pwrite_o,
    output logic [DATA_WIDTH-1:0]   m_pwdata_o,
    output logic [DATA_WIDTH/8-1:0] m_pstrb_o,
    input  logic [DATA_WIDTH-1:0]   m_prdata_i,
    input  logic                    m_pready_i,
    input  logic                    m_pslverr_i,
    output logic                    busy_o,
    output logic                    timeout_o
);

    // state  | meaning
    // IDLE   | waiting for a requester
    // SETUP  | master SETUP phase with the winner's latched fields
    // ACCESS | master ACCESS phase, timeout counter running
    // RESP   | one-cycle pready back to the granted requester
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic                   ptr_q, ptr_d;
    logic                   grant_q, grant_d;
    logic                   abort_q, abort_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
    logic [2:0]             pprot_q, pprot_d;
    logic                   pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]  pstrb_q, pstrb_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   busy_q, busy_d;
    logic                   timeout_q, timeout_d;
    logic                   s0_pready_q, s0_pready_d;
    logic                   s1_pready_q, s1_pready_d;
    logic                   s0_pslverr_q, s0_pslverr_d;
    logic                   s1_pslverr_q, s1_pslverr_d;
    logic [DATA_WIDTH-1:0]  s0_prdata_q, s0_prdata_d;
    logic [DATA_WIDTH-1:0]  s1_prdata_q, s1_prdata_d;

    logic                   req0, req1, win, granted_psel;
    logic                   resp_fire, resp_err;
    logic [DATA_WIDTH-1:0]  resp_rdata;
    logic                   unused_penable;

    assign req0           = s0_psel_i && !s0_pready_q;
    assign req1           = s1_psel_i && !s1_pready_q;
    assign win            = (req0 && req1) ? ptr_q : req1;
    assign granted_psel   = grant_q ? s1_psel_i : s0_psel_i;
    assign unused_penable = s0_penable_i ^ s1_penable_i;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        abort_d    = abort_q;
        cnt_d      = cnt_q;
        paddr_d    = paddr_q;
        pprot_d    = pprot_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        timeout_d  = 1'b0;
        resp_fire  = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d  = win;
                    ptr_d    = ~win;
                    abort_d  = 1'b0;
                    paddr_d  = win ? s1_paddr_i  : s0_paddr_i;
                    pprot_d  = win ? s1_pprot_i  : s0_pprot_i;
                    pwrite_d = win ? s1_pwrite_i : s0_pwrite_i;
                    pwdata_d = win ? s1_pwdata_i : s0_pwdata_i;
                    pstrb_d  = win ? s1_pstrb_i  : s0_pstrb_i;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                abort_d = abort_q | ~granted_psel;
                state_d = ACCESS;
            end
            ACCESS: begin
                // A requester that walks away still lets the master transfer finish
                abort_d = abort_q | ~granted_psel;
                if (m_pready_i) begin
                    resp_fire  = 1'b1;
                    resp_rdata = m_prdata_i;
                    resp_err   = m_pslverr_i;
                    state_d    = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        psel_d       = (state_d == SETUP) || (state_d == ACCESS);
        penable_d    = (state_d == ACCESS);
        busy_d       = (state_d != IDLE);
        s0_pready_d  = resp_fire && !grant_d && !abort_d;
        s1_pready_d  = resp_fire &&  grant_d && !abort_d;
        s0_prdata_d  = s0_pready_d ? resp_rdata : '0;
        s1_prdata_d  = s1_pready_d ? resp_rdata : '0;
        s0_pslverr_d = s0_pready_d && resp_err;
        s1_pslverr_d = s1_pready_d && resp_err;
    end

    always_ff @(posedge soc_clk_i or negedge soc_rstn_synced_i) begin
        if (!soc_rstn_synced_i) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            grant_q      <= 1'b0;
            abort_q      <= 1'b0;
            cnt_q        <= '0;
            paddr_q      <= '0;
            pprot_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            s0_pready_q  <= 1'b0;
            s1_pready_q  <= 1'b0;
            s0_pslverr_q <= 1'b0;
            s1_pslverr_q <= 1'b0;
            s0_prdata_q  <= '0;
            s1_prdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            abort_q      <= abort_d;
            cnt_q        <= cnt_d;
            paddr_q      <= paddr_d;
            pprot_q      <= pprot_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            s0_pready_q  <= s0_pready_d;
            s1_pready_q  <= s1_pready_d;
            s0_pslverr_q <= s0_pslverr_d;
            s1_pslverr_q <= s1_pslverr_d;
            s0_prdata_q  <= s0_prdata_d;
            s1_prdata_q  <= s1_prdata_d;
        end
    end

    assign m_paddr_o    = paddr_q;
    assign m_pprot_o    = pprot_q;
    assign m_pwrite_o   = pwrite_q;
    assign m_pwdata_o   = pwdata_q;
    assign m_pstrb_o    = pstrb_q;
    assign m_psel_o     = psel_q;
    assign m_penable_o  = penable_q;
    assign busy_o       = busy_q;
    assign timeout_o    = timeout_q;
    assign s0_pready_o  = s0_pready_q;
    assign s1_pready_o  = s1_pready_q;
    assign s0_pslverr_o = s0_pslverr_q;
    assign s1_pslverr_o = s1_pslverr_q;
    assign s0_prdata_o  = s0_prdata_q;
    assign s1_prdata_o  = s1_prdata_q;

endmodule

// File: tb/tb_apb_chip_ctrl_arbiter.sv
// Scoreboard bench for apb_chip_ctrl_arbiter: requester transactions push
// expected master fields and responses, popped when the DUT answers.
module tb_apb_chip_ctrl_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] s0_paddr_i, s1_paddr_i;
    logic [2:0]  s0_pprot_i, s1_pprot_i;
    logic        s0_psel_i, s1_psel_i, s0_penable_i, s1_penable_i;
    logic        s0_pwrite_i, s1_pwrite_i;
    logic [31:0] s0_pwdata_i, s1_pwdata_i;
    logic [3:0]  s0_pstrb_i, s1_pstrb_i;
    logic [31:0] s0_prdata_o, s1_prdata_o;
    logic        s0_pready_o, s1_pready_o, s0_pslverr_o, s1_pslverr_o;
    logic [31:0] m_paddr_o, m_pwdata_o, m_prdata_i;
    logic [2:0]  m_pprot_o;
    logic        m_psel_o, m_penable_o, m_pwrite_o;
    logic [3:0]  m_pstrb_o;
    logic        m_pready_i, m_pslverr_i;
    logic        busy_o, timeout_o;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          acc_cnt = 0;
    int          slv_wait = 0;
    logic        slv_hang = 1'b0;
    logic        slv_err = 1'b0;
    logic [31:0] slv_base = 32'h0;
    logic        ptr_model = 1'b0;

    always #5 clk = ~clk;

    apb_chip_ctrl_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .soc_clk_i(clk), .soc_rstn_synced_i(rstn),
        .s0_paddr_i(s0_paddr_i), .s0_pprot_i(s0_pprot_i), .s0_psel_i(s0_psel_i),
        .s0_penable_i(s0_penable_i), .s0_pwrite_i(s0_pwrite_i), .s0_pwdata_i(s0_pwdata_i),
        .s0_pstrb_i(s0_pstrb_i), .s0_prdata_o(s0_prdata_o), .s0_pready_o(s0_pready_o),
        .s0_pslverr_o(s0_pslverr_o),
        .s1_paddr_i(s1_paddr_i), .s1_pprot_i(s1_pprot_i), .s1_psel_i(s1_psel_i),
        .s1_penable_i(s1_penable_i), .s1_pwrite_i(s1_pwrite_i), .s1_pwdata_i(s1_pwdata_i),
        .s1_pstrb_i(s1_pstrb_i), .s1_prdata_o(s1_prdata_o), .s1_pready_o(s1_pready_o),
        .s1_pslverr_o(s1_pslverr_o),
        .m_paddr_o(m_paddr_o), .m_pprot_o(m_pprot_o), .m_psel_o(m_psel_o),
        .m_penable_o(m_penable_o), .m_pwrite_o(m_pwrite_o), .m_pwdata_o(m_pwdata_o),
        .m_pstrb_o(m_pstrb_o), .m_prdata_i(m_prdata_i), .m_pready_i(m_pready_i),
        .m_pslverr_i(m_pslverr_i), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    function automatic logic [143:0] got_all();
        return {s0_prdata_o, s0_pready_o, s0_pslverr_o, s1_prdata_o, s1_pready_o, s1_pslverr_o,
                m_paddr_o, m_pprot_o, m_psel_o, m_penable_o, m_pwrite_o, m_pwdata_o, m_pstrb_o,
                busy_o, timeout_o};
    endfunction

    function automatic logic [71:0] got_setup();
        return {m_paddr_o, m_pprot_o, m_pwrite_o, m_pwdata_o, m_pstrb_o};
    endfunction

    function automatic logic [71:0] exp_setup(input exp_t e);
        return {e.addr, e.prot, e.wr, e.wdata, e.strb};
    endfunction

    function automatic logic [67:0] got_resp();
        return {s1_pready_o, s0_pready_o, s1_prdata_o, s0_prdata_o, s1_pslverr_o, s0_pslverr_o};
    endfunction

    function automatic logic [67:0] exp_resp(input exp_t e);
        if (e.port == 1) return {2'b10, e.rdata, 32'h0, e.err, 1'b0};
        return {2'b01, 32'h0, e.rdata, 1'b0, e.err};
    endfunction

    task automatic clear_inputs();
        {s0_paddr_i, s0_pprot_i, s0_psel_i, s0_penable_i, s0_pwrite_i, s0_pwdata_i, s0_pstrb_i} = '0;
        {s1_paddr_i, s1_pprot_i, s1_psel_i, s1_penable_i, s1_pwrite_i, s1_pwdata_i, s1_pstrb_i} = '0;
        m_prdata_i = '0; m_pready_i = 1'b0; m_pslverr_i = 1'b0;
    endtask

    // One clock: the bench acts as the chip-control slave and as the two
    // requesters, which release psel once they see their pready.
    task automatic step();
        @(posedge clk); #1;
        if (m_psel_o && m_penable_o) begin
            if (!slv_hang && acc_cnt >= slv_wait) begin
                m_pready_i  = 1'b1;
                m_pslverr_i = slv_err;
                m_prdata_i  = m_pwrite_o ? 32'h0 : (slv_base ^ m_paddr_o);
            end else begin
                m_pready_i = 1'b0; m_pslverr_i = 1'b0; m_prdata_i = 32'hDEAD_BEEF;
            end
            acc_cnt++;
        end else begin
            acc_cnt = 0; m_pready_i = 1'b0; m_pslverr_i = 1'b0; m_prdata_i = '0;
        end
        if (s0_pready_o) begin s0_psel_i = 1'b0; s0_penable_i = 1'b0; end
        else if (s0_psel_i) s0_penable_i = 1'b1;
        if (s1_pready_o) begin s1_psel_i = 1'b0; s1_penable_i = 1'b0; end
        else if (s1_psel_i) s1_penable_i = 1'b1;
    endtask

    task automatic issue(input int k, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, output exp_t e);
        e.port  = k;
        e.addr  = addr;
        e.wr    = wr;
        e.wdata = wdata;
        e.prot  = (k == 1) ? 3'b101 : 3'b010;
        e.strb  = wr ? ((k == 1) ? 4'h3 : 4'hF) : 4'h0;
        e.rdata = (slv_hang || wr) ? 32'h0 : (slv_base ^ addr);
        e.err   = slv_hang ? 1'b1 : slv_err;
        if (k == 0) begin
            s0_paddr_i = addr; s0_pprot_i = e.prot; s0_pwrite_i = wr; s0_pwdata_i = wdata;
            s0_pstrb_i = e.strb; s0_penable_i = 1'b0; s0_psel_i = 1'b1;
        end else begin
            s1_paddr_i = addr; s1_pprot_i = e.prot; s1_pwrite_i = wr; s1_pwdata_i = wdata;
            s1_pstrb_i = e.strb; s1_penable_i = 1'b0; s1_psel_i = 1'b1;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (got_all() !== '0) $display("FAIL reset_outputs got %h want 0", got_all());
        else pass_cnt++;
        rstn = 1'b1;
        step();
        total_cnt++;
        if ({busy_o, m_psel_o, s0_pready_o, s1_pready_o} !== 4'b0000)
            $display("FAIL reset_idle got %b want 0000", {busy_o, m_psel_o, s0_pready_o, s1_pready_o});
        else pass_cnt++;
    endtask

    task automatic test_single_write();
        exp_t e;
        slv_wait = 0; slv_hang = 1'b0; slv_err = 1'b0;
        issue(0, 32'h1A10_4000, 1'b1, 32'hCAFE_F00D, e);
        exp_q.push_back(e);
        step();
        total_cnt++;
        if ({m_psel_o, m_penable_o, busy_o} !== 3'b101)
            $display("FAIL sw_cycle1_setup got %b want 101", {m_psel_o, m_penable_o, busy_o});
        else pass_cnt++;
        total_cnt++;
        if (got_setup() !== exp_setup(exp_q[0]))
            $display("FAIL sw_setup_fields got %h want %h", got_setup(), exp_setup(exp_q[0]));
        else pass_cnt++;
        step();
        total_cnt++;
        if ({m_psel_o, m_penable_o, s0_pready_o} !== 3'b110)
            $display("FAIL sw_cycle2_access got %b want 110", {m_psel_o, m_penable_o, s0_pready_o});
        else pass_cnt++;
        step();
        e = exp_q.pop_front();
        total_cnt++;
        if (got_resp() !== exp_resp(e))
            $display("FAIL sw_cycle3_response got %h want %h", got_resp(), exp_resp(e));
        else pass_cnt++;
        total_cnt++;
        if ({m_psel_o, m_penable_o} !== 2'b00)
            $display("FAIL sw_resp_master_idle got %b want 00", {m_psel_o, m_penable_o});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({busy_o, s0_pready_o, s0_prdata_o} !== '0)
            $display("FAIL sw_cycle4_idle got %h want 0", {busy_o, s0_pready_o, s0_prdata_o});
        else pass_cnt++;
        ptr_model = 1'b1;
    endtask

    task automatic test_round_robin();
        exp_t e, e0, e1;
        logic first;
        rstn = 1'b0; step(); rstn = 1'b1; step();
        ptr_model = 1'b0;
        slv_base = 32'h5A5A_0000;
        for (int ph = 0; ph < 3; ph++) begin
            if (ph == 1) begin
                issue(0, 32'h0000_3000, 1'b0, 32'h0, e);
                exp_q.push_back(e);
                ptr_model = 1'b1;
            end else begin
                first = ptr_model;
                issue(0, 32'h0000_1000 + 32'(ph * 16), 1'b0, 32'h0, e0);
                issue(1, 32'h0000_2000 + 32'(ph * 16), 1'b0, 32'h0, e1);
                if (first) begin exp_q.push_back(e1); exp_q.push_back(e0); end
                else begin exp_q.push_back(e0); exp_q.push_back(e1); end
                ptr_model = first;
            end
            for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
                step();
                if (m_psel_o && !m_penable_o) begin
                    total_cnt++;
                    if (got_setup() !== exp_setup(exp_q[0]))
                        $display("FAIL rr_setup ph%0d got %h want %h", ph, got_setup(), exp_setup(exp_q[0]));
                    else pass_cnt++;
                end
                if (s0_pready_o || s1_pready_o) begin
                    e = exp_q.pop_front();
                    total_cnt++;
                    if (got_resp() !== exp_resp(e))
                        $display("FAIL rr_response ph%0d got %h want %h", ph, got_resp(), exp_resp(e));
                    else pass_cnt++;
                end
            end
            total_cnt++;
            if (exp_q.size() != 0)
                $display("FAIL rr_drain ph%0d pending %0d want 0", ph, exp_q.size());
            else pass_cnt++;
            exp_q.delete();
            step(); step();
        end
        slv_base = 32'h0;
    endtask

    task automatic test_timeout();
        exp_t e;
        int acc;
        bit seen;
        slv_hang = 1'b1;
        issue(0, 32'h1A10_4008, 1'b0, 32'h0, e);
        exp_q.push_back(e);
        acc = 0; seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            step();
            if (m_psel_o && m_penable_o) acc++;
            if (s0_pready_o) begin
                seen = 1'b1;
                e = exp_q.pop_front();
                total_cnt++;
                if (got_resp() !== exp_resp(e))
                    $display("FAIL to_response got %h want %h", got_resp(), exp_resp(e));
                else pass_cnt++;
                total_cnt++;
                if (timeout_o !== 1'b1) $display("FAIL to_pulse got %b want 1", timeout_o);
                else pass_cnt++;
                total_cnt++;
                if (acc != TO) $display("FAIL to_access_cycles got %0d want %0d", acc, TO);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (!seen) $display("FAIL to_no_response got none want s0 pready");
        else pass_cnt++;
        step();
        total_cnt++;
        if ({timeout_o, busy_o, s0_pready_o} !== 3'b000)
            $display("FAIL to_after got %b want 000", {timeout_o, busy_o, s0_pready_o});
        else pass_cnt++;
        exp_q.delete();
        slv_hang = 1'b0;
        ptr_model = 1'b1;
    endtask

    task automatic test_slverr();
        exp_t e;
        slv_err = 1'b1; slv_base = 32'h55AA_55AA;
        issue(1, 32'h0000_0000, 1'b0, 32'h0, e);
        exp_q.push_back(e);
        step(); step(); step();
        e = exp_q.pop_front();
        total_cnt++;
        if (got_resp() !== exp_resp(e))
            $display("FAIL se_response got %h want %h", got_resp(), exp_resp(e));
        else pass_cnt++;
        step();
        total_cnt++;
        if (got_resp() !== '0) $display("FAIL se_one_cycle got %h want 0", got_resp());
        else pass_cnt++;
        slv_err = 1'b0; slv_base = 32'h0;
        ptr_model = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        slv_hang = 1'b1;
        issue(0, 32'h1A10_4010, 1'b0, 32'h0, e);
        step(); step();
        total_cnt++;
        if ({m_psel_o, m_penable_o} !== 2'b11)
            $display("FAIL rm_in_access got %b want 11", {m_psel_o, m_penable_o});
        else pass_cnt++;
        #1 rstn = 1'b0;
        #1;
        total_cnt++;
        if (got_all() !== '0) $display("FAIL rm_outputs_cleared got %h want 0", got_all());
        else pass_cnt++;
        s0_psel_i = 1'b0; s0_penable_i = 1'b0; slv_hang = 1'b0;
        step();
        rstn = 1'b1;
        ptr_model = 1'b0;
        issue(1, 32'h1A10_4020, 1'b1, 32'h1234_5678, e);
        exp_q.push_back(e);
        step();
        total_cnt++;
        if ({m_psel_o, m_penable_o, got_setup()} !== {2'b10, exp_setup(exp_q[0])})
            $display("FAIL rm_s1_setup got %h want %h", {m_psel_o, m_penable_o, got_setup()},
                     {2'b10, exp_setup(exp_q[0])});
        else pass_cnt++;
        step(); step();
        e = exp_q.pop_front();
        total_cnt++;
        if (got_resp() !== exp_resp(e))
            $display("FAIL rm_s1_response got %h want %h", got_resp(), exp_resp(e));
        else pass_cnt++;
        step();
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL rm_s1_idle got %b want 0", busy_o);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        exp_t e;
        bit hs, saw, done;
        slv_wait = 2;
        issue(0, 32'h1A10_4030, 1'b1, 32'hA5A5_0F0F, e);
        step(); step();
        total_cnt++;
        if (m_penable_o !== 1'b1) $display("FAIL ab_in_access got %b want 1", m_penable_o);
        else pass_cnt++;
        s0_psel_i = 1'b0; s0_penable_i = 1'b0;
        hs = 1'b0; saw = 1'b0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            step();
            if (s0_pready_o || s0_pslverr_o || (s0_prdata_o != 32'h0)) saw = 1'b1;
            if (m_psel_o && m_penable_o && m_pready_i) hs = 1'b1;
            if (!busy_o) done = 1'b1;
        end
        total_cnt++;
        if (saw) $display("FAIL ab_no_pready got pready want none");
        else pass_cnt++;
        total_cnt++;
        if (!hs) $display("FAIL ab_master_done got no handshake want handshake");
        else pass_cnt++;
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL ab_busy_after got %b want 0", busy_o);
        else pass_cnt++;
        slv_wait = 0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_timeout();
        test_slverr();
        test_reset_mid();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
